bus_cycle_ctrl: RTL and testbench

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

---
 rtl/bus_ctrl_pkg.sv | 52 +++++
 rtl/bus_status_dec.sv | 24 ++
 rtl/bus_cycle_ctrl.sv | 119 +++++++++++
 tb/tb_bus_cycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared types and status codes for the bus cycle controller.
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4
    } bus_state_e;

    typedef enum logic [2:0] {
        CYC_INTA = 3'd0,
        CYC_IORD = 3'd1,
        CYC_IOWR = 3'd2,
        CYC_HALT = 3'd3,
        CYC_MEMR = 3'd4,
        CYC_MEMW = 3'd5,
        CYC_NONE = 3'd7
    } cyc_type_e;

    localparam logic [2:0] S_INTA    = 3'b000;
    localparam logic [2:0] S_IORD    = 3'b001;
    localparam logic [2:0] S_IOWR    = 3'b010;
    localparam logic [2:0] S_HALT    = 3'b011;
    localparam logic [2:0] S_MEMR0   = 3'b100;
    localparam logic [2:0] S_MEMR1   = 3'b101;
    localparam logic [2:0] S_MEMW    = 3'b110;
    localparam logic [2:0] S_PASSIVE = 3'b111;

    function automatic logic is_write(input cyc_type_e t);
        return (t == CYC_IOWR) || (t == CYC_MEMW);
    endfunction

    function automatic logic is_io(input cyc_type_e t);
        return (t == CYC_IORD) || (t == CYC_IOWR);
    endfunction

    // Command bit order: {mrdc, mwtc, iorc, iowc, inta}, active-high here.
    function automatic logic [4:0] cmd_onehot(input cyc_type_e t);
        case (t)
            CYC_MEMR: return 5'b10000;
            CYC_MEMW: return 5'b01000;
            CYC_IORD: return 5'b00100;
            CYC_IOWR: return 5'b00010;
            CYC_INTA: return 5'b00001;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/bus_status_dec.sv
// Maps CPU status s_n to a cycle type; valid excludes passive and HALT.
module bus_status_dec
    import bus_ctrl_pkg::*;
(
    input  logic [2:0] i_s_n,
    output cyc_type_e  o_type,
    output logic       o_valid
);

    always_comb begin
        o_type  = CYC_NONE;
        o_valid = 1'b0;
        case (i_s_n)
            S_INTA:           begin o_type = CYC_INTA; o_valid = 1'b1; end
            S_IORD:           begin o_type = CYC_IORD; o_valid = 1'b1; end
            S_IOWR:           begin o_type = CYC_IOWR; o_valid = 1'b1; end
            S_HALT:           begin o_type = CYC_HALT; o_valid = 1'b0; end
            S_MEMR0, S_MEMR1: begin o_type = CYC_MEMR; o_valid = 1'b1; end
            S_MEMW:           begin o_type = CYC_MEMW; o_valid = 1'b1; end
            default:          begin o_type = CYC_NONE; o_valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: T1-T4 sequencing with wait states and DMA (aen) gating.
// Define BUS_IO_WAIT_EN to force one wait state on every I/O cycle.
module bus_cycle_ctrl
    import bus_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] s_n,
    input  logic       ready,
    input  logic       aen,
    output logic       ale,
    output logic       addr_oe_n,
    output logic       den,
    output logic       dt_r,
    output logic       mrdc_n,
    output logic       mwtc_n,
    output logic       iorc_n,
    output logic       iowc_n,
    output logic       inta_n,
    output logic       busy
);

`ifdef BUS_IO_WAIT_EN
    localparam logic IO_WAIT = 1'b1;
`else
    localparam logic IO_WAIT = 1'b0;
`endif

    bus_state_e r_state;
    cyc_type_e  r_type;
    logic       r_ale;
    logic       r_den;
    logic       r_dtr;
    logic       r_busy;
    logic [4:0] r_cmd;

    cyc_type_e  w_type;
    logic       w_valid;
    logic       w_start;
    bus_state_e w_nxt_state;
    cyc_type_e  w_nxt_type;
    logic       w_cmd_phase;

    bus_status_dec u_dec (
        .i_s_n   (s_n),
        .o_type  (w_type),
        .o_valid (w_valid)
    );

    assign w_start = w_valid & ~aen;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_type  = r_type;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_nxt_state = ST_T1;
                    w_nxt_type  = w_type;
                end
            end
            ST_T1: w_nxt_state = ST_T2;
            ST_T2: w_nxt_state = ST_T3;
            ST_T3: begin
                if (IO_WAIT && is_io(r_type))
                    w_nxt_state = ST_TW;
                else
                    w_nxt_state = ready ? ST_T4 : ST_TW;
            end
            ST_TW: w_nxt_state = ready ? ST_T4 : ST_TW;
            ST_T4: begin
                if (w_start) begin
                    w_nxt_state = ST_T1;
                    w_nxt_type  = w_type;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign w_cmd_phase = (w_nxt_state == ST_T2) || (w_nxt_state == ST_T3) ||
                         (w_nxt_state == ST_TW);

    // Outputs are decoded from the next state so each register equals the Moore decode of r_state/r_type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_type  <= CYC_NONE;
            r_ale   <= 1'b0;
            r_den   <= 1'b0;
            r_dtr   <= 1'b0;
            r_busy  <= 1'b0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_type  <= w_nxt_type;
            r_ale   <= (w_nxt_state == ST_T1);
            r_den   <= w_cmd_phase;
            r_dtr   <= (w_nxt_state != ST_IDLE) && is_write(w_nxt_type);
            r_busy  <= (w_nxt_state != ST_IDLE);
            r_cmd   <= w_cmd_phase ? cmd_onehot(w_nxt_type) : '0;
        end
    end

    // DMA ownership masks bus drive combinationally; the state sequence is untouched.
    assign ale       = r_ale & ~aen;
    assign den       = r_den & ~aen;
    assign addr_oe_n = rst | aen;
    assign dt_r      = r_dtr;
    assign busy      = r_busy;
    assign mrdc_n    = ~(r_cmd[4] & ~aen);
    assign mwtc_n    = ~(r_cmd[3] & ~aen);
    assign iorc_n    = ~(r_cmd[2] & ~aen);
    assign iowc_n    = ~(r_cmd[1] & ~aen);
    assign inta_n    = ~(r_cmd[0] & ~aen);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized scoreboard bench for bus_cycle_ctrl with directed DMA and reset cases.
module tb_bus_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] s_n;
    logic       ready;
    logic       aen;
    logic       ale, addr_oe_n, den, dt_r;
    logic       mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] cmd;
        int         len;
        logic       dtr;
    } exp_t;

    exp_t q[$];
    logic mon_en = 1'b0;
    logic in_cyc = 1'b0;

    bus_cycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .s_n       (s_n),
        .ready     (ready),
        .aen       (aen),
        .ale       (ale),
        .addr_oe_n (addr_oe_n),
        .den       (den),
        .dt_r      (dt_r),
        .mrdc_n    (mrdc_n),
        .mwtc_n    (mwtc_n),
        .iorc_n    (iorc_n),
        .iowc_n    (iowc_n),
        .inta_n    (inta_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] RST_OUTS  = 10'b0_1_0_0_11111_0;
    localparam logic [9:0] IDLE_OUTS = 10'b0_0_0_0_11111_0;

    function automatic logic [9:0] outs();
        return {ale, addr_oe_n, den, dt_r, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, busy};
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Reference: command line, length of command (T2+T3+waits) and direction per status code.
    function automatic exp_t model(input logic [2:0] st, input int nz);
        exp_t e;
        logic io;
        io = (st == 3'b001) || (st == 3'b010);
        case (st)
            3'b000:          e.cmd = 5'b00001;
            3'b001:          e.cmd = 5'b00100;
            3'b010:          e.cmd = 5'b00010;
            3'b100, 3'b101:  e.cmd = 5'b10000;
            default:         e.cmd = 5'b01000;
        endcase
        e.dtr = (st == 3'b010) || (st == 3'b110);
        e.len = 2 + nz;
`ifdef BUS_IO_WAIT_EN
        if (io && nz == 0) e.len = 3;
`else
        if (io) e.len = 2 + nz;
`endif
        return e;
    endfunction

    // Entered #1 after a posedge with the DUT in IDLE or T4; leaves #1 after entering T4.
    task automatic run_cycle(input logic [2:0] st, input int nz);
        exp_t e;
        e = model(st, nz);
        q.push_back(e);
        s_n = st; aen = 1'b0; ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        s_n = 3'b111; ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int i = 0; i < e.len - 1; i++) begin
            ready = (i >= nz);
            @(posedge clk); #1;
        end
        ready = 1'($urandom_range(0, 1));
    endtask

    initial begin : monitor
        logic [4:0] w;
        logic [4:0] seen;
        int run_len;
        exp_t e;
        run_len = 0;
        seen = '0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                w = {~mrdc_n, ~mwtc_n, ~iorc_n, ~iowc_n, ~inta_n};
                if (w != 0) begin
                    checks++;
                    if ($countones(w) != 1) begin
                        errors++;
                        $display("FAIL one_cmd: got %b expected one-hot", w);
                    end
                end
                if (ale) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cycle: got ale=1 expected no cycle");
                    end else if (dt_r !== q[0].dtr) begin
                        errors++;
                        $display("FAIL dtr_t1: got %b expected %b", dt_r, q[0].dtr);
                    end
                    in_cyc = 1'b1;
                    run_len = 0;
                    seen = '0;
                end else if (in_cyc) begin
                    if (w != 0) begin
                        run_len++;
                        seen = w;
                        checks++;
                        if (den !== 1'b1) begin
                            errors++;
                            $display("FAIL den_cmd: got %b expected 1", den);
                        end
                    end else if (run_len > 0 || busy !== 1'b1) begin
                        in_cyc = 1'b0;
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_empty: got end of cycle expected none");
                        end else begin
                            e = q.pop_front();
                            if (seen !== e.cmd || run_len != e.len || dt_r !== e.dtr ||
                                busy !== 1'b1 || den !== 1'b0) begin
                                errors++;
                                $display("FAIL cycle: got cmd=%b len=%0d dtr=%b busy=%b den=%b expected cmd=%b len=%0d dtr=%b busy=1 den=0",
                                         seen, run_len, dt_r, busy, den, e.cmd, e.len, e.dtr);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [2:0] codes [6];
        logic [2:0] st;
        codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
        codes[3] = 3'b100; codes[4] = 3'b101; codes[5] = 3'b110;

        rst = 1'b1; s_n = 3'b111; ready = 1'b1; aen = 1'b0;
        #3;
        chk("reset_outs", outs(), RST_OUTS);
        @(posedge clk); #1;
        chk("reset_hold", outs(), RST_OUTS);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", outs(), IDLE_OUTS);

        s_n = 3'b011;
        repeat (3) @(posedge clk);
        #1 chk("halt_idle", outs(), IDLE_OUTS);
        s_n = 3'b111;
        @(posedge clk); #1;

        mon_en = 1'b1;
        run_cycle(3'b101, 0);
        s_n = 3'b111; @(posedge clk); #1;
        chk("memr_idle_after", outs(), IDLE_OUTS);
        run_cycle(3'b110, 3);
        s_n = 3'b111; @(posedge clk); #1;
        run_cycle(3'b001, 0);
        s_n = 3'b111; @(posedge clk); #1;
        run_cycle(3'b010, 1);
        run_cycle(3'b101, 0);
        s_n = 3'b011; @(posedge clk); #1;

        for (int n = 0; n < 80; n++) begin
            st = codes[$urandom_range(0, 5)];
            run_cycle(st, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    case ($urandom_range(0, 2))
                        0: begin s_n = 3'b111; aen = 1'b0; end
                        1: begin s_n = 3'b011; aen = 1'b0; end
                        default: begin s_n = codes[$urandom_range(0, 5)]; aen = 1'b1; end
                    endcase
                    @(posedge clk); #1;
                end
                aen = 1'b0;
            end
        end
        s_n = 3'b111; aen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0 || in_cyc) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        mon_en = 1'b0;

        s_n = 3'b101; ready = 1'b1;
        @(posedge clk); #1;
        s_n = 3'b111;
        @(posedge clk); #1;
        chk("memr_t2", outs(), 10'b0_0_1_0_01111_1);
        aen = 1'b1; #1;
        chk("aen_gate", outs(), 10'b0_1_0_0_11111_1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_n = 3'b101;
        chk("aen_t4_busy", outs(), 10'b0_1_0_0_11111_1);
        @(posedge clk); #1;
        chk("aen_no_start", outs(), 10'b0_1_0_0_11111_0);
        @(posedge clk); #1;
        chk("aen_no_start2", outs(), 10'b0_1_0_0_11111_0);
        aen = 1'b0; s_n = 3'b111;
        @(posedge clk); #1;
        chk("aen_release", outs(), IDLE_OUTS);

        s_n = 3'b110; ready = 1'b0;
        @(posedge clk); #1;
        s_n = 3'b111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("memw_tw", outs(), 10'b0_0_1_1_10111_1);
        #1 rst = 1'b1;
        #1 chk("rst_async", outs(), RST_OUTS);
        s_n = 3'b011; ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rst_halt_idle", outs(), IDLE_OUTS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
